// File: rtl/klp32_pkg.sv
// Shared types for the klp32 iterative multiply/divide unit.
// Operation codes follow the RV32M funct3 field.
package klp32_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/klp32_muldiv.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on magnitudes,
// sharing one counter, accumulator and operand register; divide-by-zero/overflow take a 1-cycle path.
//
// state | meaning
// IDLE  | o_ready high, waiting for a request
// BUSY  | one multiply/divide step per cycle for XLEN cycles
// DONE  | o_valid high, result held until i_ready
module klp32_muldiv
  import klp32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN);
  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     r_state;
  logic [CW-1:0]     r_cnt;
  muldiv_op_e        r_op;
  logic              r_neg;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_result;

  muldiv_op_e      w_op;
  logic            w_is_div;
  logic            w_is_rem;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_neg;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_fast_res;
  logic            w_accept;

  assign w_op     = muldiv_op_e'(i_op);
  assign w_is_div = op_is_div(w_op);
  assign w_is_rem = i_op[1];

  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (w_op)
      OP_MULH, OP_DIV, OP_REM: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
      end
      OP_MULHSU: w_a_signed = 1'b1;
      default: ;
    endcase
  end

  assign w_a_neg  = w_a_signed & i_rs1[XLEN-1];
  assign w_b_neg  = w_b_signed & i_rs2[XLEN-1];
  assign w_a_mag  = w_a_neg ? (~i_rs1 + 1'b1) : i_rs1;
  assign w_b_mag  = w_b_neg ? (~i_rs2 + 1'b1) : i_rs2;
  // Remainder follows the dividend sign; quotient and product follow the sign xor.
  assign w_neg    = (w_is_div && w_is_rem) ? w_a_neg : (w_a_neg ^ w_b_neg);
  assign w_div0   = w_is_div && (i_rs2 == '0);
  assign w_ovf    = w_is_div && !i_op[0] && (i_rs1 == MOST_NEG) && (i_rs2 == ALL_ONES);
  assign w_fast_res = w_div0 ? (w_is_rem ? i_rs1 : ALL_ONES)
                             : (w_is_rem ? '0 : i_rs1);
  assign w_accept = i_valid && (r_state == ST_IDLE);

  logic [XLEN-1:0]   w_hi;
  logic [XLEN-1:0]   w_lo;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_rsh;
  logic              w_ge;
  logic [XLEN-1:0]   w_diff;
  logic [2*XLEN-1:0] w_acc_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_q;
  logic [XLEN-1:0]   w_r;
  logic [XLEN-1:0]   w_final;

  assign w_hi   = r_acc[2*XLEN-1:XLEN];
  assign w_lo   = r_acc[XLEN-1:0];
  assign w_sum  = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
  assign w_rsh  = {w_hi, w_lo[XLEN-1]};
  assign w_ge   = (w_rsh >= {1'b0, r_b});
  // When the trial subtract succeeds the true difference is below r_b, so XLEN bits suffice.
  assign w_diff = w_rsh[XLEN-1:0] - r_b;

  assign w_acc_next = op_is_div(r_op)
      ? {(w_ge ? w_diff : w_rsh[XLEN-1:0]), w_lo[XLEN-2:0], w_ge}
      : {w_sum, w_lo[XLEN-1:1]};

  assign w_prod = r_neg ? (~w_acc_next + 1'b1) : w_acc_next;
  assign w_q    = w_acc_next[XLEN-1:0];
  assign w_r    = w_acc_next[2*XLEN-1:XLEN];

  always_comb begin
    w_final = '0;
    case (r_op)
      OP_MUL:                       w_final = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_final = r_neg ? (~w_q + 1'b1) : w_q;
      OP_REM, OP_REMU:              w_final = r_neg ? (~w_r + 1'b1) : w_r;
      default:                      w_final = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_op     <= OP_MUL;
      r_neg    <= 1'b0;
      r_b      <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op  <= w_op;
            r_neg <= w_neg;
            // Divide: dividend shifts out of the low half; multiply: multiplier does.
            r_b   <= w_is_div ? w_b_mag : w_a_mag;
            r_acc <= {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
            if (w_div0 || w_ovf) begin
              r_result <= w_fast_res;
              r_state  <= ST_DONE;
            end else begin
              r_cnt   <= CNT_LOAD;
              r_state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_result <= w_final;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ready  = (r_state == ST_IDLE);
  assign o_valid  = (r_state == ST_DONE);
  assign o_busy   = (r_state == ST_BUSY);
  assign o_result = r_result;

endmodule

// File: tb/tb_klp32_muldiv.sv
// Directed self-checking bench for klp32_muldiv at XLEN=32.
module tb_klp32_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [2:0]  i_op = 3'b000;
  logic [31:0] i_rs1 = '0;
  logic [31:0] i_rs2 = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_result;
  logic        o_busy;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  klp32_muldiv #(.XLEN(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_op    (i_op),
    .i_rs1   (i_rs1),
    .i_rs2   (i_rs2),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_result(o_result),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  // Issue one request, scramble inputs after accept, measure cycles to o_valid, then consume.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    @(negedge clk);
    i_op = op; i_rs1 = a; i_rs2 = b; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0; i_op = ~op; i_rs1 = ~a; i_rs2 = a ^ 32'h5a5a_5a5a;
    lat = 1;
    @(negedge clk);
    while (!o_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!o_valid) lat = -1;
    res = o_result;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic run_table(input string tag, input vec_t q[$]);
    logic [31:0] res;
    int lat;
    foreach (q[i]) begin
      do_op(q[i].op, q[i].a, q[i].b, res, lat);
      n_total++;
      if (res !== q[i].exp) begin
        n_bad++;
        $display("FAIL %s[%0d] result op=%0d: got %h expected %h", tag, i, q[i].op, res, q[i].exp);
      end
      n_total++;
      if (lat !== q[i].lat) begin
        n_bad++;
        $display("FAIL %s[%0d] latency op=%0d: got %0d expected %0d", tag, i, q[i].op, lat, q[i].lat);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    n_total++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_result !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b res=%h expected 1 0 0 0",
               o_ready, o_valid, o_busy, o_result);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_total++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: got rdy=%b vld=%b expected 1 0", o_ready, o_valid);
    end
  endtask

  task automatic test_mul();
    vec_t q[$];
    q.push_back('{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
    q.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33});
    q.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
    q.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33});
    q.push_back('{3'b001, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 33});
    q.push_back('{3'b000, 32'h0001_0003, 32'h0001_0002, 32'h0005_0006, 33});
    q.push_back('{3'b011, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, 33});
    run_table("mul", q);
  endtask

  task automatic test_div();
    vec_t q[$];
    q.push_back('{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33});
    q.push_back('{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33});
    q.push_back('{3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 33});
    q.push_back('{3'b101, 32'd100,       32'd7,         32'd14,        33});
    q.push_back('{3'b111, 32'd100,       32'd7,         32'd2,         33});
    q.push_back('{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33});
    q.push_back('{3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         33});
    q.push_back('{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         33});
    run_table("div", q);
  endtask

  task automatic test_fast_path();
    vec_t q[$];
    q.push_back('{3'b100, 32'd5,         32'h0,         32'hFFFF_FFFF, 1});
    q.push_back('{3'b110, 32'd5,         32'h0,         32'd5,         1});
    q.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
    q.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1});
    q.push_back('{3'b101, 32'd9,         32'h0,         32'hFFFF_FFFF, 1});
    q.push_back('{3'b111, 32'd9,         32'h0,         32'd9,         1});
    run_table("fast", q);
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    i_op = 3'b000; i_rs1 = 32'd7; i_rs2 = 32'd3; i_valid = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    @(negedge clk);
    while (!o_valid && lat < 100) begin
      i_rs1 = i_rs1 + 32'd1;
      @(negedge clk);
      lat++;
    end
    n_total++;
    if (lat !== 33) begin
      n_bad++;
      $display("FAIL b2b_first_latency: got %0d expected 33", lat);
    end
    for (int k = 0; k < 5; k++) begin
      i_rs1 = 32'd100 + k; i_rs2 = 32'd50 - k; i_op = 3'(k);
      @(negedge clk);
      n_total++;
      if (o_result !== 32'd21 || o_valid !== 1'b1 || o_ready !== 1'b0 || o_busy !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_hold[%0d]: got res=%h vld=%b rdy=%b busy=%b expected 15 1 0 0",
                 k, o_result, o_valid, o_ready, o_busy);
      end
    end
    i_op = 3'b000; i_rs1 = 32'd2; i_rs2 = 32'd9; i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    n_total++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0 || o_result !== 32'd21) begin
      n_bad++;
      $display("FAIL b2b_bubble: got vld=%b rdy=%b busy=%b res=%h expected 0 1 0 15",
               o_valid, o_ready, o_busy, o_result);
    end
    @(negedge clk);
    i_valid = 1'b0;
    n_total++;
    if (o_busy !== 1'b1 || o_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_second_accept: got busy=%b rdy=%b expected 1 0", o_busy, o_ready);
    end
    lat = 1;
    while (!o_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    n_total++;
    if (lat !== 33 || o_result !== 32'd18) begin
      n_bad++;
      $display("FAIL b2b_second_result: got lat=%0d res=%h expected 33 12", lat, o_result);
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] res;
    int lat;
    int spurious;
    @(negedge clk);
    i_op = 3'b000; i_rs1 = 32'h0001_2345; i_rs2 = 32'h10; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (o_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_busy_before: got busy=%b expected 1", o_busy);
    end
    reset = 1'b1;
    #1;
    n_total++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b1 || o_result !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_mid_busy: got vld=%b busy=%b rdy=%b res=%h expected 0 0 1 0",
               o_valid, o_busy, o_ready, o_result);
    end
    @(negedge clk);
    reset = 1'b0;
    spurious = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_valid || o_busy) spurious++;
    end
    n_total++;
    if (spurious !== 0) begin
      n_bad++;
      $display("FAIL rst_discard: got %0d active cycles expected 0", spurious);
    end
    do_op(3'b000, 32'd3, 32'd4, res, lat);
    n_total++;
    if (res !== 32'd12 || lat !== 33) begin
      n_bad++;
      $display("FAIL rst_then_mul: got res=%h lat=%0d expected c 33", res, lat);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_back_to_back();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
